// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encoding and helpers for the iterative mul/div unit
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } mdState_t;

    // Every divide/remainder opcode has funct3[2] set.
    function automatic logic isDivOp(input logic [2:0] f);
        return f >= MD_DIV;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add multiply or restoring divide iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              isDiv,
    input  logic [2*XLEN-1:0] work,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] nextWork
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum      = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, operand};
        // Shifted remainder needs XLEN+1 bits; the restored difference always fits XLEN.
        partial  = work[2*XLEN-1:XLEN-1];
        diff     = work[2*XLEN-2:XLEN-1] - operand;
        nextWork = work;
        if (isDiv) begin
            if (partial >= {1'b0, operand}) begin
                nextWork = {diff, work[XLEN-2:0], 1'b1};
            end else begin
                nextWork = {work[2*XLEN-2:0], 1'b0};
            end
        end else if (work[0]) begin
            nextWork = {sum, work[XLEN-1:1]};
        end else begin
            nextWork = {1'b0, work[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/multiciclo_muldiv.sv
// rtl/multiciclo_muldiv.sv - iterative RV32M multiply/divide unit with start/done handshake and flush
module multiciclo_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    mdState_t          state;
    logic [CW-1:0]     counter;
    logic [2:0]        opReg;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] work, nextWork, prodFix;
    logic              negRes, negRem;
    logic              aSigned, bSigned, aNeg, bNeg, divZero, divOvf;
    logic [XLEN-1:0]   absA, absB, quoFix, remFix, fixResult;

    assign busy = (state != MD_IDLE);

    always_comb begin
        aSigned = funct3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        bSigned = funct3 inside {MD_MULH, MD_DIV, MD_REM};
        aNeg    = aSigned & opA[XLEN-1];
        bNeg    = bSigned & opB[XLEN-1];
        absA    = aNeg ? -opA : opA;
        absB    = bNeg ? -opB : opB;
        divZero = isDivOp(funct3) && (opB == '0);
        divOvf  = ((funct3 == MD_DIV) || (funct3 == MD_REM)) && (opA == MIN_NEG) && (opB == ALL_ONES);
    end

    always_comb begin
        prodFix = negRes ? -work : work;
        quoFix  = negRes ? -work[XLEN-1:0] : work[XLEN-1:0];
        remFix  = negRem ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
        case (opReg)
            MD_MUL:                      fixResult = prodFix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fixResult = prodFix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             fixResult = quoFix;
            default:                     fixResult = remFix;
        endcase
    end

    muldiv_step #(.XLEN(XLEN)) uStep (
        .isDiv   (isDivOp(opReg)),
        .work    (work),
        .operand (operand),
        .nextWork(nextWork)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MD_IDLE;
            counter <= '0;
            opReg   <= '0;
            operand <= '0;
            work    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state   <= MD_IDLE;
                counter <= '0;
            end else begin
                case (state)
                    MD_IDLE: if (start) begin
                        opReg <= funct3;
                        // Special cases preload the final {remainder, quotient} with no sign fix-up.
                        if (divZero || divOvf) begin
                            work   <= divZero ? {opA, ALL_ONES} : {{XLEN{1'b0}}, opA};
                            negRes <= 1'b0;
                            negRem <= 1'b0;
                            state  <= MD_FIX;
                        end else begin
                            operand <= isDivOp(funct3) ? absB : absA;
                            work    <= {{XLEN{1'b0}}, (isDivOp(funct3) ? absA : absB)};
                            negRes  <= aNeg ^ bNeg;
                            negRem  <= aNeg;
                            counter <= CW'(XLEN - 1);
                            state   <= MD_CALC;
                        end
                    end
                    MD_CALC: begin
                        work <= nextWork;
                        if (counter == '0) begin
                            state <= MD_FIX;
                        end else begin
                            counter <= counter - CNT_ONE;
                        end
                    end
                    MD_FIX: begin
                        result <= fixResult;
                        done   <= 1'b1;
                        state  <= MD_IDLE;
                    end
                    default: state <= MD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multiciclo_muldiv.sv
// tb/tb_multiciclo_muldiv.sv - scoreboard bench for multiciclo_muldiv at XLEN=32 and XLEN=16
module tb_multiciclo_muldiv;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clock = 1'b0;
    logic        reset_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] opA, opB, result;
    logic        busy, done;

    logic        start16, flush16;
    logic [2:0]  funct16;
    logic [15:0] opA16, opB16, result16;
    logic        busy16, done16;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } expEntry_t;

    expEntry_t sb32[$];
    expEntry_t sb16[$];
    int nChecks = 0;
    int nErrors = 0;
    int cycle = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    multiciclo_muldiv #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .funct3(funct3),
        .opA(opA), .opB(opB), .flush(flush), .busy(busy), .done(done), .result(result)
    );

    multiciclo_muldiv #(.XLEN(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start16), .funct3(funct16),
        .opA(opA16), .opB(opB16), .flush(flush16), .busy(busy16), .done(done16), .result(result16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb32.size() == 0) begin
                check("unexpected_done32", 32'd1, 32'd0);
            end else begin
                expEntry_t e;
                e = sb32.pop_front();
                check("result32", result, e.res);
                check("latency32", cycle - e.t0, e.lat);
            end
        end
        if (reset_n && done16) begin
            if (sb16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                expEntry_t e;
                e = sb16.pop_front();
                check("result16", {16'h0, result16}, e.res);
                check("latency16", cycle - e.t0, e.lat);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic track, input logic [31:0] res, input int lat);
        start = 1'b1; funct3 = f; opA = a; opB = b;
        if (track) sb32.push_back('{res, lat, cycle});
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input int lat);
        start16 = 1'b1; funct16 = f; opA16 = a; opB16 = b;
        sb16.push_back('{{16'h0, res}, lat, cycle});
        @(negedge clock);
        start16 = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || busy16) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy || busy16) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
        issue(f, a, b, 1'b1, res, lat);
        waitIdle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; opA = '0; opB = '0;
        start16 = 1'b0; flush16 = 1'b0; funct16 = '0; opA16 = '0; opB16 = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 34);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("mul_busy_cycles", n, 32'd33);

        run(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run(MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run(DIVU,   32'd100,       32'd7,         32'd14,        34);
        run(REMU,   32'd100,       32'd7,         32'd2,         34);
        run(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run(REM,    32'd5,         32'd0,         32'd5,         2);
        run(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        // start re-pulsed mid-operation must not disturb the MUL in flight
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 34);
        repeat (8) @(negedge clock);
        start = 1'b1; funct3 = DIVU; opA = 32'd100; opB = 32'd7;
        @(negedge clock);
        start = 1'b0;
        waitIdle();

        // flush at cycle 20 of an untracked MUL
        issue(MUL, 32'd3, 32'd5, 1'b0, 32'd0, 0);
        repeat (18) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, 32'hFFFF_FFEB);
        repeat (40) @(negedge clock);

        // asynchronous reset in the middle of a DIV
        issue(DIV, 32'd100, 32'd7, 1'b0, 32'd0, 0);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_done", {31'b0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // back-to-back: second start issued in the done cycle of the first
        issue(DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("b2b_done_timeout", 32'd1, 32'd0);
        issue(REMU, 32'd100, 32'd7, 1'b1, 32'd2, 34);
        waitIdle();

        issue16(MUL, 16'h00FF, 16'h0101, 16'hFFFF, 18);
        waitIdle();
        issue16(DIV, 16'h8000, 16'hFFFF, 16'h8000, 2);
        waitIdle();
        issue16(REM, 16'hFFF9, 16'd2, 16'hFFFF, 18);
        waitIdle();

        repeat (3) @(negedge clock);
        check("sb32_drained", sb32.size(), 32'd0);
        check("sb16_drained", sb16.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
